// File: rtl/ucsbece154a_memarb.sv
// Two-requester memory arbiter: core and loader/debug ports share one
// registered memory request port. Round-robin on ties, bounded memory wait
// with a timeout error, one-cycle completion/error pulses.
module ucsbece154a_memarb #(
   parameter int TIMEOUT = 15,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req_i,
   input  logic          c_we_i,
   input  logic [AW-1:0] c_adr_i,
   input  logic [AW-1:0] c_wd_i,
   output logic          c_ack_o,
   output logic          c_err_o,
   input  logic          d_req_i,
   input  logic          d_we_i,
   input  logic [AW-1:0] d_adr_i,
   input  logic [AW-1:0] d_wd_i,
   output logic          d_ack_o,
   output logic          d_err_o,
   output logic [AW-1:0] rd_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_adr_o,
   output logic [AW-1:0] mem_wd_o,
   input  logic [AW-1:0] mem_rd_i,
   input  logic          mem_ack_i
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   // 1 = loader granted last (and is the current winner while BUSY/DONE)
   logic          ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_adr_q, mem_adr_d;
   logic [AW-1:0] mem_wd_q, mem_wd_d;
   logic [AW-1:0] rd_q, rd_d;
   logic          c_ack_q, c_ack_d;
   logic          c_err_q, c_err_d;
   logic          d_ack_q, d_ack_d;
   logic          d_err_q, d_err_d;
   logic          sel_loader;

   // Winner pick: on a tie the side not granted last wins, a lone requester always wins
   always_comb begin
      sel_loader = d_req_i;
      if (c_req_i && d_req_i) sel_loader = ~ptr_q;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      mem_req_d = mem_req_q;
      mem_we_d  = mem_we_q;
      mem_adr_d = mem_adr_q;
      mem_wd_d  = mem_wd_q;
      rd_d      = rd_q;
      c_ack_d   = 1'b0;
      c_err_d   = 1'b0;
      d_ack_d   = 1'b0;
      d_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (c_req_i || d_req_i) begin
               ptr_d     = sel_loader;
               mem_req_d = 1'b1;
               mem_we_d  = sel_loader ? d_we_i  : c_we_i;
               mem_adr_d = sel_loader ? d_adr_i : c_adr_i;
               mem_wd_d  = sel_loader ? d_wd_i  : c_wd_i;
               cnt_d     = '0;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            // An ack in the final wait cycle takes priority over the timeout
            if (mem_ack_i) begin
               rd_d      = mem_rd_i;
               mem_req_d = 1'b0;
               c_ack_d   = ~ptr_q;
               d_ack_d   = ptr_q;
               state_d   = DONE;
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               c_err_d   = ~ptr_q;
               d_err_d   = ptr_q;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            // Requests are not sampled here so the requester can drop its request
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b1;
         cnt_q     <= '0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         mem_adr_q <= '0;
         mem_wd_q  <= '0;
         rd_q      <= '0;
         c_ack_q   <= 1'b0;
         c_err_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         d_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
         mem_adr_q <= mem_adr_d;
         mem_wd_q  <= mem_wd_d;
         rd_q      <= rd_d;
         c_ack_q   <= c_ack_d;
         c_err_q   <= c_err_d;
         d_ack_q   <= d_ack_d;
         d_err_q   <= d_err_d;
      end
   end

   assign c_ack_o   = c_ack_q;
   assign c_err_o   = c_err_q;
   assign d_ack_o   = d_ack_q;
   assign d_err_o   = d_err_q;
   assign rd_o      = rd_q;
   assign mem_req_o = mem_req_q;
   assign mem_we_o  = mem_we_q;
   assign mem_adr_o = mem_adr_q;
   assign mem_wd_o  = mem_wd_q;

endmodule

// File: tb/tb_ucsbece154a_memarb.sv
// Directed bench for the two-port memory arbiter (TIMEOUT = 4).
module tb_ucsbece154a_memarb;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          c_req_i, c_we_i;
   logic [AW-1:0] c_adr_i, c_wd_i;
   logic          c_ack_o, c_err_o;
   logic          d_req_i, d_we_i;
   logic [AW-1:0] d_adr_i, d_wd_i;
   logic          d_ack_o, d_err_o;
   logic [AW-1:0] rd_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_adr_o, mem_wd_o;
   logic [AW-1:0] mem_rd_i;
   logic          mem_ack_i;

   int n_checks = 0;
   int n_fail   = 0;
   int overlap  = 0;
   logic [AW-1:0] last_rd;

   ucsbece154a_memarb #(.TIMEOUT(4), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .c_req_i   (c_req_i),
      .c_we_i    (c_we_i),
      .c_adr_i   (c_adr_i),
      .c_wd_i    (c_wd_i),
      .c_ack_o   (c_ack_o),
      .c_err_o   (c_err_o),
      .d_req_i   (d_req_i),
      .d_we_i    (d_we_i),
      .d_adr_i   (d_adr_i),
      .d_wd_i    (d_wd_i),
      .d_ack_o   (d_ack_o),
      .d_err_o   (d_err_o),
      .rd_o      (rd_o),
      .mem_req_o (mem_req_o),
      .mem_we_o  (mem_we_o),
      .mem_adr_o (mem_adr_o),
      .mem_wd_o  (mem_wd_o),
      .mem_rd_i  (mem_rd_i),
      .mem_ack_i (mem_ack_i)
   );

   always #5 clk = ~clk;

   // Any cycle with two completion/error pulses at once is a violation
   always @(negedge clk) begin
      if (!reset && ((c_ack_o + c_err_o + d_ack_o + d_err_o) > 1)) overlap++;
   end

   task automatic check_val(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      c_req_i = 0; c_we_i = 0; c_adr_i = '0; c_wd_i = '0;
      d_req_i = 0; d_we_i = 0; d_adr_i = '0; d_wd_i = '0;
      mem_rd_i = '0; mem_ack_i = 0;

      // ---------------- reset state
      step();
      check_val("rst_mem_req", {31'b0, mem_req_o}, 0);
      check_val("rst_mem_we",  {31'b0, mem_we_o}, 0);
      check_val("rst_mem_adr", mem_adr_o, 0);
      check_val("rst_mem_wd",  mem_wd_o, 0);
      check_val("rst_rd",      rd_o, 0);
      check_val("rst_acks",    {28'b0, c_ack_o, c_err_o, d_ack_o, d_err_o}, 0);
      reset = 1'b0;

      // ---------------- core read 0x10, memory acks 2 cycles after mem_req_o
      c_req_i = 1; c_we_i = 0; c_adr_i = 32'h10; c_wd_i = 32'h0;
      step();
      check_val("t1_mem_req", {31'b0, mem_req_o}, 1);
      check_val("t1_mem_adr", mem_adr_o, 32'h10);
      check_val("t1_mem_we",  {31'b0, mem_we_o}, 0);
      step();
      check_val("t1_wait_req", {31'b0, mem_req_o}, 1);
      check_val("t1_wait_ack", {31'b0, c_ack_o}, 0);
      step();
      mem_ack_i = 1; mem_rd_i = 32'hDEADBEEF;
      step();
      mem_ack_i = 0; mem_rd_i = 32'h0; c_req_i = 0;
      check_val("t1_c_ack",   {31'b0, c_ack_o}, 1);
      check_val("t1_d_ack",   {31'b0, d_ack_o}, 0);
      check_val("t1_c_err",   {31'b0, c_err_o}, 0);
      check_val("t1_rd",      rd_o, 32'hDEADBEEF);
      check_val("t1_req_low", {31'b0, mem_req_o}, 0);
      step();
      check_val("t1_ack_1cyc", {31'b0, c_ack_o}, 0);

      // ---------------- stray memory ack in IDLE is ignored
      mem_ack_i = 1; mem_rd_i = 32'h0BADF00D;
      step();
      mem_ack_i = 0;
      check_val("stray_req",  {31'b0, mem_req_o}, 0);
      check_val("stray_ack",  {30'b0, c_ack_o, d_ack_o}, 0);
      check_val("stray_rd",   rd_o, 32'hDEADBEEF);

      // ---------------- reset, then both requesters held, zero-wait memory
      reset = 1'b1;
      step();
      reset = 1'b0;
      c_req_i = 1; c_we_i = 0; c_adr_i = 32'h100;
      d_req_i = 1; d_we_i = 0; d_adr_i = 32'h200;
      for (int t = 0; t < 3; t++) begin
         logic       exp_d;
         logic [AW-1:0] val;
         exp_d = (t == 1);
         val   = 32'h1111_0000 + t;
         step();
         check_val($sformatf("rr%0d_req", t), {31'b0, mem_req_o}, 1);
         check_val($sformatf("rr%0d_adr", t), mem_adr_o, exp_d ? 32'h200 : 32'h100);
         mem_ack_i = 1; mem_rd_i = val;
         step();
         mem_ack_i = 0;
         check_val($sformatf("rr%0d_c_ack", t), {31'b0, c_ack_o}, {31'b0, ~exp_d});
         check_val($sformatf("rr%0d_d_ack", t), {31'b0, d_ack_o}, {31'b0, exp_d});
         check_val($sformatf("rr%0d_rd", t), rd_o, val);
         last_rd = val;
         step();
         check_val($sformatf("rr%0d_idle", t), {29'b0, c_ack_o, d_ack_o, mem_req_o}, 0);
         if (t == 2) begin
            c_req_i = 0; d_req_i = 0;
         end
      end

      // ---------------- loader write 0x55 to 0x40, memory never acks
      d_req_i = 1; d_we_i = 1; d_adr_i = 32'h40; d_wd_i = 32'h55;
      for (int k = 0; k < 4; k++) begin
         step();
         check_val($sformatf("to_req%0d", k), {31'b0, mem_req_o}, 1);
         check_val($sformatf("to_err%0d", k), {31'b0, d_err_o}, 0);
         if (k == 0) begin
            check_val("to_we",  {31'b0, mem_we_o}, 1);
            check_val("to_adr", mem_adr_o, 32'h40);
            check_val("to_wd",  mem_wd_o, 32'h55);
         end
      end
      step();
      d_req_i = 0;
      check_val("to_req_low", {31'b0, mem_req_o}, 0);
      check_val("to_d_err",   {31'b0, d_err_o}, 1);
      check_val("to_d_ack",   {31'b0, d_ack_o}, 0);
      check_val("to_c_err",   {31'b0, c_err_o}, 0);
      check_val("to_rd_hold", rd_o, last_rd);
      step();
      check_val("to_err_1cyc", {31'b0, d_err_o}, 0);
      // Back in IDLE: a new request is granted on the very next edge
      c_req_i = 1; c_we_i = 0; c_adr_i = 32'h44;
      step();
      check_val("late_req", {31'b0, mem_req_o}, 1);
      check_val("late_adr", mem_adr_o, 32'h44);
      // ---------------- ack on the 4th BUSY cycle beats the timeout
      step();
      step();
      step();
      mem_ack_i = 1; mem_rd_i = 32'hCAFEF00D;
      step();
      mem_ack_i = 0; c_req_i = 0;
      check_val("late_c_ack", {31'b0, c_ack_o}, 1);
      check_val("late_c_err", {31'b0, c_err_o}, 0);
      check_val("late_rd",    rd_o, 32'hCAFEF00D);
      step();
      check_val("late_clear", {30'b0, c_ack_o, c_err_o}, 0);

      // ---------------- reset asserted mid-BUSY
      c_req_i = 1; c_we_i = 0; c_adr_i = 32'h30;
      step();
      check_val("mid_busy_req", {31'b0, mem_req_o}, 1);
      #2;
      reset = 1'b1; c_req_i = 0;
      #1;
      check_val("mid_rst_req", {31'b0, mem_req_o}, 0);
      check_val("mid_rst_adr", mem_adr_o, 0);
      check_val("mid_rst_pulses", {28'b0, c_ack_o, c_err_o, d_ack_o, d_err_o}, 0);
      step();
      reset = 1'b0;
      c_req_i = 1; c_we_i = 0; c_adr_i = 32'h20;
      step();
      check_val("post_rst_req", {31'b0, mem_req_o}, 1);
      check_val("post_rst_adr", mem_adr_o, 32'h20);
      mem_ack_i = 1; mem_rd_i = 32'h12345678;
      step();
      mem_ack_i = 0; c_req_i = 0;
      check_val("post_rst_ack", {31'b0, c_ack_o}, 1);
      check_val("post_rst_rd",  rd_o, 32'h12345678);
      step();
      check_val("post_rst_idle", {30'b0, c_ack_o, mem_req_o}, 0);

      check_val("pulse_overlap", overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
